// File: rtl/dram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dram_port_arbiter
// Description : Round-robin sharing of one MIG UI wrapper between an I-side
//               and a D-side requester, with in-order read-return routing.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_port_arbiter #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = 16,
    parameter int TAG_DEPTH  = 8
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic                  i_p0_req,
    input  logic                  i_p0_we,
    input  logic [ADDR_WIDTH-1:0] i_p0_addr,
    input  logic [DATA_WIDTH-1:0] i_p0_wdata,
    input  logic [MASK_WIDTH-1:0] i_p0_mask,
    output logic                  o_p0_ack,
    output logic [DATA_WIDTH-1:0] o_p0_rdata,
    output logic                  o_p0_rvalid,
    input  logic                  i_p1_req,
    input  logic                  i_p1_we,
    input  logic [ADDR_WIDTH-1:0] i_p1_addr,
    input  logic [DATA_WIDTH-1:0] i_p1_wdata,
    input  logic [MASK_WIDTH-1:0] i_p1_mask,
    output logic                  o_p1_ack,
    output logic [DATA_WIDTH-1:0] o_p1_rdata,
    output logic                  o_p1_rvalid,
    output logic                  o_dram_rd_en,
    output logic                  o_dram_wr_en,
    output logic [ADDR_WIDTH-1:0] o_dram_addr,
    output logic [DATA_WIDTH-1:0] o_dram_data,
    output logic [MASK_WIDTH-1:0] o_dram_mask,
    input  logic [DATA_WIDTH-1:0] i_dram_data,
    input  logic                  i_dram_data_valid,
    input  logic                  i_dram_ready,
    input  logic                  i_dram_wdf_ready,
    input  logic                  i_init_calib_complete,
    output logic                  o_busy,
    output logic                  o_err
);

    localparam int c_PTR_W = $clog2(TAG_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(TAG_DEPTH);

    localparam logic [1:0] c_ST_CALIB = 2'd0;
    localparam logic [1:0] c_ST_ARB   = 2'd1;
    localparam logic [1:0] c_ST_ISSUE = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic                  r_prio;        // 0: port 0 wins a tie, 1: port 1 wins
    logic                  r_cmd_we;
    logic [ADDR_WIDTH-1:0] r_cmd_addr;
    logic [DATA_WIDTH-1:0] r_cmd_data;
    logic [MASK_WIDTH-1:0] r_cmd_mask;

    logic [TAG_DEPTH-1:0]  r_tag;
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0]    r_count;

    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_p0_rvalid;
    logic                  r_p1_rvalid;
    logic                  r_err;

    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic                  w_elig0;
    logic                  w_elig1;
    logic                  w_ack0;
    logic                  w_ack1;
    logic                  w_grant;
    logic                  w_sel_we;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fifo_empty;
    logic                  w_head;

    assign w_fifo_empty = (r_count == '0);
    assign w_wr_ok      = i_dram_ready & i_dram_wdf_ready;
    assign w_rd_ok      = i_dram_ready & (r_count != c_DEPTH);
    assign w_elig0      = i_p0_req & (i_p0_we ? w_wr_ok : w_rd_ok);
    assign w_elig1      = i_p1_req & (i_p1_we ? w_wr_ok : w_rd_ok);

    always_comb begin
        w_state_nxt = r_state;
        w_ack0      = 1'b0;
        w_ack1      = 1'b0;
        case (r_state)
            c_ST_CALIB: begin
                if (i_init_calib_complete) begin
                    w_state_nxt = c_ST_ARB;
                end
            end
            c_ST_ARB: begin
                if (w_elig0 | w_elig1) begin
                    w_state_nxt = c_ST_ISSUE;
                    if (w_elig0 & (~w_elig1 | ~r_prio)) begin
                        w_ack0 = 1'b1;
                    end else begin
                        w_ack1 = 1'b1;
                    end
                end
            end
            c_ST_ISSUE: begin
                w_state_nxt = c_ST_ARB;
            end
            default: begin
                w_state_nxt = c_ST_CALIB;
            end
        endcase
    end

    assign w_grant  = w_ack0 | w_ack1;
    assign w_sel_we = w_ack1 ? i_p1_we : i_p0_we;
    assign w_push   = w_grant & ~w_sel_we;
    assign w_pop    = i_dram_data_valid & ~w_fifo_empty;
    assign w_head   = r_tag[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state <= c_ST_CALIB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Command latch and round-robin pointer
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_prio     <= 1'b0;
            r_cmd_we   <= 1'b0;
            r_cmd_addr <= '0;
            r_cmd_data <= '0;
            r_cmd_mask <= '0;
        end else if (w_grant) begin
            r_prio     <= ~w_ack1;
            r_cmd_we   <= w_sel_we;
            r_cmd_addr <= w_ack1 ? i_p1_addr  : i_p0_addr;
            r_cmd_data <= w_ack1 ? i_p1_wdata : i_p0_wdata;
            r_cmd_mask <= w_ack1 ? i_p1_mask  : i_p0_mask;
        end
    end

    // In-order tag FIFO holding the requester ID of each outstanding read
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_tag    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_tag[r_wr_ptr] <= w_ack1;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_rdata     <= '0;
            r_p0_rvalid <= 1'b0;
            r_p1_rvalid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_p0_rvalid <= w_pop & ~w_head;
            r_p1_rvalid <= w_pop & w_head;
            if (w_pop) begin
                r_rdata <= i_dram_data;
            end
            // A beat with nothing outstanding cannot be routed; flag it forever
            if (i_dram_data_valid & w_fifo_empty) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_p0_ack     = w_ack0;
    assign o_p1_ack     = w_ack1;
    assign o_p0_rdata   = r_rdata;
    assign o_p1_rdata   = r_rdata;
    assign o_p0_rvalid  = r_p0_rvalid;
    assign o_p1_rvalid  = r_p1_rvalid;
    assign o_dram_rd_en = (r_state == c_ST_ISSUE) & ~r_cmd_we;
    assign o_dram_wr_en = (r_state == c_ST_ISSUE) & r_cmd_we;
    assign o_dram_addr  = r_cmd_addr;
    assign o_dram_data  = r_cmd_data;
    assign o_dram_mask  = r_cmd_mask;
    assign o_busy       = ~w_fifo_empty | (r_state == c_ST_ISSUE);
    assign o_err        = r_err;

endmodule
`default_nettype wire
